// File: rtl/bp_cce_pending_write_arbiter_if.sv
// Handshake and write-port bundle for the pending-bit write arbiter.
// The master side is the CCE request/response logic, and the slave side is the arbiter.
interface bp_cce_pending_write_arbiter_if #(
  parameter int paddr_width_p = 40
);
  logic                     inc_v_i;
  logic [paddr_width_p-1:0] inc_addr_i;
  logic                     inc_ready_o;
  logic                     dec_v_i;
  logic [paddr_width_p-1:0] dec_addr_i;
  logic                     dec_ready_o;
  logic                     sweep_i;
  logic                     sweep_busy_o;
  logic                     w_v_o;
  logic [paddr_width_p-1:0] w_addr_o;
  logic                     w_addr_bypass_hash_o;
  logic                     pending_o;
  logic                     clear_o;
  logic [15:0]              outstanding_o;
  logic                     underflow_o;

  modport master (
    output inc_v_i, inc_addr_i, dec_v_i, dec_addr_i, sweep_i,
    input  inc_ready_o, dec_ready_o, sweep_busy_o, w_v_o, w_addr_o,
           w_addr_bypass_hash_o, pending_o, clear_o, outstanding_o, underflow_o
  );

  modport slave (
    input  inc_v_i, inc_addr_i, dec_v_i, dec_addr_i, sweep_i,
    output inc_ready_o, dec_ready_o, sweep_busy_o, w_v_o, w_addr_o,
           w_addr_bypass_hash_o, pending_o, clear_o, outstanding_o, underflow_o
  );
endinterface

// File: rtl/bp_cce_pending_write_arbiter.sv
// Pending-bit write arbiter: merges LCE increments, buffered memory-response
// decrements and a hardware clear sweep into one pending-bit write per cycle.
// Optional feature macro: BP_CCE_PENDING_TRACK_EN (outstanding count and underflow flag).
module bp_cce_pending_write_arbiter #(
  parameter int paddr_width_p    = 40,
  parameter int num_way_groups_p = 8,
  parameter int dec_fifo_els_p   = 4
) (
  input logic                           clk_i,
  input logic                           reset_n_i,
  bp_cce_pending_write_arbiter_if.slave bus
);

  localparam int lg_num_way_groups_lp = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1;
  localparam int ptr_w_lp = $clog2(dec_fifo_els_p);
  localparam int cnt_w_lp = $clog2(dec_fifo_els_p + 1);

  typedef enum logic {e_sweep = 1'b0, e_ready = 1'b1} state_e;

  state_e state_q, state_d;

  logic [lg_num_way_groups_lp-1:0] sweep_cnt_q;
  logic [paddr_width_p-1:0]        fifo_mem_q [dec_fifo_els_p];
  logic [ptr_w_lp-1:0]             rd_ptr_q, wr_ptr_q;
  logic [cnt_w_lp-1:0]             count_q;

  logic                     fifo_full, fifo_empty;
  logic                     enq, deq, inc_fire, sweep_accept, sweep_last;
  logic [paddr_width_p-1:0] fifo_head, sweep_addr;

  logic                     w_v, w_bypass, w_pending, w_clear;
  logic [paddr_width_p-1:0] w_addr;
  logic                     inc_ready, dec_ready, sweep_busy;

  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(dec_fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full    = (count_q == cnt_w_lp'(dec_fifo_els_p));
  assign fifo_empty   = (count_q == '0);
  assign fifo_head    = fifo_mem_q[rd_ptr_q];
  assign sweep_last   = (sweep_cnt_q == lg_num_way_groups_lp'(num_way_groups_p - 1));
  // A full FIFO takes precedence over increments so decrements can never starve.
  assign inc_fire     = (state_q == e_ready) & ~fifo_full & bus.inc_v_i;
  assign deq          = (state_q == e_ready) & (fifo_full | (~bus.inc_v_i & ~fifo_empty));
  assign enq          = (state_q == e_ready) & ~fifo_full & bus.dec_v_i;
  // Sweep is only taken when nothing else wants the write port; requests are not queued.
  assign sweep_accept = (state_q == e_ready) & fifo_empty & ~bus.inc_v_i & bus.sweep_i;

  // Zero-extend the sweep index onto the address bus.
  always_comb begin
    sweep_addr = '0;
    sweep_addr[lg_num_way_groups_lp-1:0] = sweep_cnt_q;
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_sweep;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_sweep: if (sweep_last)   state_d = e_ready;
      e_ready: if (sweep_accept) state_d = e_sweep;
      default: state_d = e_sweep;
    endcase
  end

  // Output decode: write port mux and handshake readies.
  always_comb begin
    w_v        = 1'b0;
    w_addr     = '0;
    w_bypass   = 1'b0;
    w_pending  = 1'b0;
    w_clear    = 1'b0;
    inc_ready  = 1'b0;
    dec_ready  = 1'b0;
    sweep_busy = 1'b0;
    case (state_q)
      e_sweep: begin
        sweep_busy = 1'b1;
        w_v        = 1'b1;
        w_clear    = 1'b1;
        w_bypass   = 1'b1;
        w_addr     = sweep_addr;
      end
      e_ready: begin
        dec_ready = ~fifo_full;
        if (fifo_full) begin
          w_v    = 1'b1;
          w_addr = fifo_head;
        end else if (bus.inc_v_i) begin
          inc_ready = 1'b1;
          w_v       = 1'b1;
          w_pending = 1'b1;
          w_addr    = bus.inc_addr_i;
        end else if (!fifo_empty) begin
          w_v    = 1'b1;
          w_addr = fifo_head;
        end
      end
      default: ;
    endcase
  end

  // Sweep index: walks 0..num_way_groups_p-1, restarts on an accepted request.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sweep_cnt_q <= '0;
    end else if (state_q == e_sweep) begin
      sweep_cnt_q <= sweep_last ? '0 : sweep_cnt_q + 1'b1;
    end else if (sweep_accept) begin
      sweep_cnt_q <= '0;
    end
  end

  // Decrement FIFO storage; contents are meaningless until the count covers them.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem_q[wr_ptr_q] <= bus.dec_addr_i;
  end

  // Decrement FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (deq) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef BP_CCE_PENDING_TRACK_EN
  logic [15:0] outstanding_q;
  logic        underflow_q;

  // Net increment/decrement tracking; a decrement at zero flags a sticky underflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else if (state_q == e_sweep) begin
      outstanding_q <= '0;
    end else if (inc_fire) begin
      outstanding_q <= outstanding_q + 16'd1;
    end else if (deq) begin
      if (outstanding_q == '0) underflow_q   <= 1'b1;
      else                     outstanding_q <= outstanding_q - 16'd1;
    end
  end

  assign bus.outstanding_o = outstanding_q;
  assign bus.underflow_o   = underflow_q;
`else
  assign bus.outstanding_o = '0;
  assign bus.underflow_o   = 1'b0;
`endif

  assign bus.w_v_o                = w_v;
  assign bus.w_addr_o             = w_addr;
  assign bus.w_addr_bypass_hash_o = w_bypass;
  assign bus.pending_o            = w_pending;
  assign bus.clear_o              = w_clear;
  assign bus.inc_ready_o          = inc_ready;
  assign bus.dec_ready_o          = dec_ready;
  assign bus.sweep_busy_o         = sweep_busy;

endmodule

// File: tb/tb_bp_cce_pending_write_arbiter.sv
// Scoreboard bench for the pending-bit write arbiter: a queue-based reference
// model predicts each cycle's writes and handshakes; a monitor compares them.
module tb_bp_cce_pending_write_arbiter;
  localparam int PW = 12, NW = 8, DEPTH = 4;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_cce_pending_write_arbiter_if #(.paddr_width_p(PW)) bus ();

  bp_cce_pending_write_arbiter #(
    .paddr_width_p(PW), .num_way_groups_p(NW), .dec_fifo_els_p(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus)
  );

  typedef struct packed {
    logic [PW-1:0] addr;
    logic          bypass;
    logic          pending;
    logic          clear;
  } wr_t;

  typedef struct packed {
    logic        inc_ready;
    logic        dec_ready;
    logic        busy;
    logic [15:0] outstanding;
    logic        underflow;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state: sweep progress, decrement queue, tracking counters.
  bit            m_sweeping = 1'b1;
  int            m_idx = 0;
  logic [PW-1:0] m_fifo[$];
  int            m_out = 0;
  bit            m_uf = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_dec();
    if (m_out == 0) m_uf = 1'b1;
    else            m_out = m_out - 1;
  endfunction

  function automatic st_t status_now(input bit inc_r, input bit dec_r, input bit busy);
    st_t s;
    s.inc_ready = inc_r;
    s.dec_ready = dec_r;
    s.busy      = busy;
`ifdef BP_CCE_PENDING_TRACK_EN
    s.outstanding = 16'(m_out);
    s.underflow   = m_uf;
`else
    s.outstanding = 16'd0;
    s.underflow   = 1'b0;
`endif
    return s;
  endfunction

  // Hold reset for n cycles; during reset the arbiter presents sweep index 0.
  task automatic reset_cycles(input int n);
    wr_t w;
    repeat (n) begin
      @(negedge clk_i);
      reset_n_i = 1'b0;
      bus.inc_v_i = 1'b0; bus.dec_v_i = 1'b0; bus.sweep_i = 1'b0;
      #1;
      m_sweeping = 1'b1; m_idx = 0; m_fifo.delete(); m_out = 0; m_uf = 1'b0;
      sq.push_back(status_now(1'b0, 1'b0, 1'b1));
      w.addr = '0; w.bypass = 1'b1; w.pending = 1'b0; w.clear = 1'b1;
      wq.push_back(w);
    end
  endtask

  // One cycle of stimulus plus the model's prediction for that cycle.
  task automatic drive(input bit iv, input logic [PW-1:0] ia, input bit dv,
                       input logic [PW-1:0] da, input bit sw, output bit inc_acc);
    st_t s;
    wr_t w;
    bit  have_w, empty0, dec_r;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    bus.inc_v_i = iv; bus.inc_addr_i = ia;
    bus.dec_v_i = dv; bus.dec_addr_i = da;
    bus.sweep_i = sw;
    #1;
    inc_acc = 1'b0;
    have_w  = 1'b0;
    w = '0;
    if (m_sweeping) begin
      s = status_now(1'b0, 1'b0, 1'b1);
      w.addr = PW'(m_idx); w.bypass = 1'b1; w.clear = 1'b1;
      have_w = 1'b1;
      m_out = 0;
      if (m_idx == NW - 1) m_sweeping = 1'b0;
      else                 m_idx = m_idx + 1;
    end else begin
      empty0 = (m_fifo.size() == 0);
      dec_r  = (m_fifo.size() < DEPTH);
      s = status_now(iv && dec_r, dec_r, 1'b0);
      if (m_fifo.size() == DEPTH) begin
        w.addr = m_fifo.pop_front(); have_w = 1'b1; model_dec();
      end else if (iv) begin
        inc_acc = 1'b1;
        w.addr = ia; w.pending = 1'b1; have_w = 1'b1;
        m_out = (m_out + 1) % 65536;
      end else if (!empty0) begin
        w.addr = m_fifo.pop_front(); have_w = 1'b1; model_dec();
      end
      if (dv && dec_r) m_fifo.push_back(da);
      if (sw && empty0 && !iv) begin
        m_sweeping = 1'b1; m_idx = 0;
      end
    end
    sq.push_back(s);
    if (have_w) wq.push_back(w);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive(1'b0, '0, 1'b0, '0, 1'b0, a);
  endtask

  // Monitor: compares status every cycle and pops an expected write whenever the DUT writes.
  initial begin
    st_t e;
    wr_t w;
    forever begin
      @(negedge clk_i);
      #2;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("inc_ready_o", bus.inc_ready_o, e.inc_ready);
        chk("dec_ready_o", bus.dec_ready_o, e.dec_ready);
        chk("sweep_busy_o", bus.sweep_busy_o, e.busy);
        chk("outstanding_o", bus.outstanding_o, e.outstanding);
        chk("underflow_o", bus.underflow_o, e.underflow);
      end
      chk("w_v_o", bus.w_v_o, wq.size() > 0);
      if (bus.w_v_o && wq.size() > 0) begin
        w = wq.pop_front();
        chk("w_addr_o", bus.w_addr_o, w.addr);
        chk("w_addr_bypass_hash_o", bus.w_addr_bypass_hash_o, w.bypass);
        chk("pending_o", bus.pending_o, w.pending);
        chk("clear_o", bus.clear_o, w.clear);
        $display("write addr=%0h bypass=%0b pending=%0b clear=%0b outstanding=%0d",
                 bus.w_addr_o, bus.w_addr_bypass_hash_o, bus.pending_o, bus.clear_o,
                 bus.outstanding_o);
      end else if (wq.size() > 0) begin
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit inc_pend;
    logic [PW-1:0] inc_a;
    int guard;
    bus.inc_v_i = 1'b0; bus.inc_addr_i = '0;
    bus.dec_v_i = 1'b0; bus.dec_addr_i = '0;
    bus.sweep_i = 1'b0;

    // Reset, then the power-on sweep of NW clear writes.
    reset_cycles(3);
    idle(NW + 1);

    // Same-cycle increment and decrement with an empty FIFO.
    drive(1'b1, 12'h123, 1'b1, 12'h456, 1'b0, acc);
    idle(2);

    // Continuous increment while four decrements fill the FIFO.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, PW'(12'h200 + i), 1'b1, PW'(12'h300 + i), 1'b0, acc);
    guard = 0;
    do begin
      drive(1'b1, 12'h2ff, 1'b0, '0, 1'b0, acc);
      guard++;
    end while (!acc && guard < 20);
    idle(DEPTH + 1);

    // Sweep request with a non-empty FIFO is dropped; with it empty it runs.
    drive(1'b0, '0, 1'b1, 12'h777, 1'b0, acc);
    drive(1'b0, '0, 1'b0, '0, 1'b1, acc);
    idle(2);
    drive(1'b0, '0, 1'b0, '0, 1'b1, acc);
    idle(NW + 1);

    // Reset in the middle of a sweep, with a decrement queued at sweep acceptance.
    drive(1'b0, '0, 1'b1, 12'h555, 1'b1, acc);
    idle(3);
    reset_cycles(2);
    idle(NW + 3);

    // Tracking: two increments, then three decrements.
    drive(1'b1, 12'h010, 1'b0, '0, 1'b0, acc);
    drive(1'b1, 12'h011, 1'b0, '0, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, PW'(12'h020 + i), 1'b0, acc);
    idle(3);

    // Randomized traffic; an increment is held until the model accepts it.
    inc_pend = 1'b0;
    inc_a = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!inc_pend && $urandom_range(0, 9) < 4) begin
        inc_pend = 1'b1;
        inc_a = PW'($urandom);
      end
      drive(inc_pend, inc_a, $urandom_range(0, 9) < 4, PW'($urandom),
            $urandom_range(0, 49) == 0, acc);
      if (acc) inc_pend = 1'b0;
    end
    idle(NW + DEPTH + 4);

    @(negedge clk_i);
    #3;
    chk("leftover_writes", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
